burst_mem_responder: RTL and testbench

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

---
 rtl/burst_mem_responder.sv | 156 +++++++++++++++
 tb/tb_burst_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// -----------------------------------------------------------------------------
// burst_mem_responder
//
// Line-oriented memory target. A request accepted in IDLE latches the line
// index and direction, waits LATENCY cycles, then transfers the 256-bit line
// as four back-to-back 64-bit beats (beat 0 = bits [63:0]). One DONE cycle
// follows the last beat. Dropping the accepted request line during WAIT or
// BEAT aborts the burst. Beats already written stay written.
//
// Ports
//   clk        single clock, rising edge
//   reset_n    asynchronous active-low reset
//   read_i     line read request, held for the whole burst
//   write_i    line write request, held for the whole burst (wins over read)
//   address_i  byte address; line index = address_i[5 +: log2(DEPTH_LINES)]
//   burst_i    write beat data
//   burst_o    read beat data, registered, zero outside read beats
//   resp_o     registered per-beat strobe
//   busy_o     high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module burst_mem_responder #(
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] address_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o,
  output logic        busy_o
);

  localparam int LW = $clog2(DEPTH_LINES);
  localparam int AW = LW + 2;                       // word address = {line, beat}
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      beat_q, beat_d;
  logic [LW-1:0]   line_q;
  logic            is_write_q;
  logic            accept;
  logic            req_held;
  logic            resp_d;
  logic [63:0]     burst_d;
  logic            mem_we;

  // Storage kept as 64-bit words so each beat is a whole-word write.
  logic [63:0]     mem [4*DEPTH_LINES];

  // Address bits outside the line index are deliberately ignored.
  logic            unused_addr;
  assign unused_addr = ^{address_i[31:5+LW], address_i[4:0]};

  // The opposite request line and the address are not looked at after
  // acceptance; only the accepted direction keeps the burst alive.
  assign req_held = is_write_q ? write_i : read_i;

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    resp_d  = 1'b0;
    accept  = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write_i || read_i) begin
          accept  = 1'b1;
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (!req_held) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          // This edge is E0+LATENCY: beat 0 strobe appears in the next cycle.
          state_d = BEAT;
          beat_d  = 2'd0;
          resp_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BEAT: begin
        if (!req_held) begin
          // Abort: the beat on the bus at this edge is not captured.
          state_d = IDLE;
        end else begin
          mem_we = is_write_q;
          if (beat_q == 2'd3) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 2'd1;
            resp_d = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data for the beat being launched; zero for writes and idle cycles.
  always_comb begin
    burst_d = 64'h0;
    if (resp_d && !is_write_q) burst_d = mem[{line_q, beat_d}];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      line_q     <= '0;
      is_write_q <= 1'b0;
      resp_o     <= 1'b0;
      burst_o    <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      resp_o  <= resp_d;
      burst_o <= burst_d;
      if (accept) begin
        line_q     <= address_i[5 +: LW];
        is_write_q <= write_i;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are undefined until
  // written. Reset still blocks a pending write because it forces the FSM to
  // IDLE asynchronously, which drops mem_we before the capture edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem[{line_q, beat_q}] <= burst_i;
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_burst_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_burst_mem_responder
//
// Directed bench for burst_mem_responder (DEPTH_LINES=64, LATENCY=4).
// A table of burst transactions (direction, address, line data, optional
// abort beat) is applied in order; reads carry hand-computed expected lines.
// Reset-during-burst corner cases are hand-written sequences afterwards.
// -----------------------------------------------------------------------------
module tb_burst_mem_responder;

  localparam int DEPTH_LINES = 64;
  localparam int LATENCY     = 4;

  logic        clk;
  logic        reset_n;
  logic        read_i;
  logic        write_i;
  logic [31:0] address_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;
  logic        busy_o;

  int tests_run;
  int tests_failed;

  burst_mem_responder #(
    .DEPTH_LINES(DEPTH_LINES),
    .LATENCY    (LATENCY)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .read_i   (read_i),
    .write_i  (write_i),
    .address_i(address_i),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .resp_o   (resp_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [255:0] data;   // write: data driven; read: expected line
    int          drop_at; // beat during which the request is dropped, -1 = none
  } vec_t;

  // Runs one burst starting just after a clock edge with the FSM in IDLE.
  task automatic run_burst(input vec_t v);
    bit is_wr;
    is_wr     = v.wr;
    write_i   = v.wr;
    read_i    = v.rd;
    address_i = v.addr;
    burst_i   = 64'h0;
    @(posedge clk); #1;                                     // acceptance edge E0
    check($sformatf("%s accept busy", v.name), 64'(busy_o), 64'd1);
    check($sformatf("%s accept resp", v.name), 64'(resp_o), 64'd0);
    // Disturb address and the opposite request line; both must be ignored.
    address_i = v.addr ^ 32'h0000_0FE0;
    if (is_wr) read_i = 1'b1; else write_i = 1'b1;
    for (int c = 1; c < LATENCY; c++) begin
      @(posedge clk); #1;
      check($sformatf("%s wait%0d resp", v.name, c), 64'(resp_o), 64'd0);
    end
    @(posedge clk); #1;                                     // edge E0+LATENCY
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s beat%0d resp", v.name, k), 64'(resp_o), 64'd1);
      check($sformatf("%s beat%0d data", v.name, k), burst_o,
            is_wr ? 64'h0 : v.data[64*k +: 64]);
      if (k == v.drop_at) begin
        if (is_wr) write_i = 1'b0; else read_i = 1'b0;
        @(posedge clk); #1;
        check($sformatf("%s abort resp", v.name), 64'(resp_o), 64'd0);
        check($sformatf("%s abort busy", v.name), 64'(busy_o), 64'd0);
        write_i = 1'b0;
        read_i  = 1'b0;
        return;
      end
      burst_i = is_wr ? v.data[64*k +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      @(posedge clk); #1;
    end
    check($sformatf("%s done resp", v.name), 64'(resp_o), 64'd0);
    check($sformatf("%s done busy", v.name), 64'(busy_o), 64'd1);
    check($sformatf("%s done data", v.name), burst_o, 64'h0);
    write_i = 1'b0;
    read_i  = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s idle busy", v.name), 64'(busy_o), 64'd0);
  endtask

  localparam logic [255:0] D1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [255:0] D2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                 64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_5555_AAAA};
  localparam logic [255:0] DA = {4{64'hAAAA_AAAA_AAAA_AAAA}};
  localparam logic [255:0] D3 = {64'h3333_0003_3333_0003, 64'h3333_0002_3333_0002,
                                 64'h3333_0001_3333_0001, 64'h3333_0000_3333_0000};
  localparam logic [255:0] D4 = {64'hCAFE_0004_0000_0800, 64'hCAFE_0003_0000_0800,
                                 64'hCAFE_0002_0000_0800, 64'hCAFE_0001_0000_0800};
  localparam logic [255:0] D5 = {64'h7777_0000_0000_003F, 64'h6666_0000_0000_003F,
                                 64'h5555_0000_0000_003F, 64'h4444_0000_0000_003F};
  localparam logic [255:0] D6 = {64'h6666_6666_0000_0003, 64'h6666_6666_0000_0002,
                                 64'h6666_6666_0000_0001, 64'h6666_6666_0000_0000};

  vec_t vecs[13];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n   = 1'b0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = 32'h0;
    burst_i   = 64'h0;

    vecs[0]  = '{"wr40",      1'b1, 1'b0, 32'h0000_0040, D1, -1};
    vecs[1]  = '{"rd40",      1'b0, 1'b1, 32'h0000_0040, D1, -1};
    vecs[2]  = '{"wrboth80",  1'b1, 1'b1, 32'h0000_0080, D2, -1};
    vecs[3]  = '{"rd80",      1'b0, 1'b1, 32'h0000_0080, D2, -1};
    vecs[4]  = '{"wr100aa",   1'b1, 1'b0, 32'h0000_0100, DA, -1};
    vecs[5]  = '{"wr100drop", 1'b1, 1'b0, 32'h0000_0100, D3, 2};
    vecs[6]  = '{"rd100",     1'b0, 1'b1, 32'h0000_0100,
                 {DA[255:128], D3[127:0]}, -1};
    vecs[7]  = '{"wr800",     1'b1, 1'b0, 32'h0000_0800, D4, -1};
    vecs[8]  = '{"rd000",     1'b0, 1'b1, 32'h0000_0000, D4, -1};
    vecs[9]  = '{"rd01f",     1'b0, 1'b1, 32'h0000_001F, D4, -1};
    vecs[10] = '{"wr7ff",     1'b1, 1'b0, 32'h0000_07FF, D5, -1};
    vecs[11] = '{"rdffe0",    1'b0, 1'b1, 32'h0000_FFE0, D5, -1};
    vecs[12] = '{"rd40drop",  1'b0, 1'b1, 32'h0000_0040, D1, 0};

    // Reset values, including that a held request is not taken during reset.
    #12;
    check("rst resp", 64'(resp_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst data", burst_o, 64'h0);
    write_i = 1'b1;
    @(posedge clk); #1;
    check("rst held req busy", 64'(busy_o), 64'd0);
    write_i = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post rst idle busy", 64'(busy_o), 64'd0);

    for (int i = 0; i < 13; i++) run_burst(vecs[i]);

    // Reset during WAIT of a read: outputs drop without a clock edge, and the
    // still-held read is accepted on the first edge after release.
    read_i    = 1'b1;
    address_i = 32'h0000_0040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstwait busy before", 64'(busy_o), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstwait busy async", 64'(busy_o), 64'd0);
    check("rstwait resp async", 64'(resp_o), 64'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rstwait reaccept busy", 64'(busy_o), 64'd1);
    for (int c = 1; c < LATENCY; c++) begin
      @(posedge clk); #1;
      check($sformatf("rstwait wait%0d resp", c), 64'(resp_o), 64'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rstwait beat%0d resp", k), 64'(resp_o), 64'd1);
      check($sformatf("rstwait beat%0d data", k), burst_o, D1[64*k +: 64]);
      @(posedge clk); #1;
    end
    check("rstwait done resp", 64'(resp_o), 64'd0);
    read_i = 1'b0;
    @(posedge clk); #1;

    // Reset during beat 1 of a write: beat 0 stored, beat 1 capture pre-empted.
    write_i   = 1'b1;
    address_i = 32'h0000_0040;
    @(posedge clk); #1;
    for (int c = 1; c < LATENCY; c++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("rstbeat beat0 resp", 64'(resp_o), 64'd1);
    burst_i = D6[63:0];
    @(posedge clk); #1;
    check("rstbeat beat1 resp", 64'(resp_o), 64'd1);
    burst_i = D6[127:64];
    #2 reset_n = 1'b0;
    #1;
    check("rstbeat resp async", 64'(resp_o), 64'd0);
    check("rstbeat busy async", 64'(busy_o), 64'd0);
    write_i = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    run_burst('{"rd40after", 1'b0, 1'b1, 32'h0000_0040,
                {D1[255:64], D6[63:0]}, -1});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
